bram_fifo: RTL and testbench
============================

BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of each stored word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4: log2 of storage depth, where DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port flush  input  1: synchronous discard of all contents.
REQ-006 The block SHALL have ports s_data  input  DATA_WIDTH, s_valid  input  1 and s_ready  output  1: the write-side handshake.
REQ-007 The block SHALL have ports m_data  output  DATA_WIDTH, m_valid  output  1 and m_ready  input  1: the read-side handshake, first-word-fall-through.
REQ-008 The block SHALL have port level  output  ADDR_WIDTH+1: count of accepted-but-not-popped words, range 0..DEPTH.
REQ-009 The block SHALL have ports full  output  1 and empty  output  1: full is level==DEPTH; empty is level==0.

Function
REQ-010 Push: a word SHALL be accepted on a rising edge where s_valid && s_ready are both high.
REQ-011 Pop: the head word SHALL be removed on a rising edge where m_valid && m_ready are both high.
REQ-012 s_ready SHALL equal !full, so a push into a full FIFO is never accepted, even when a pop occurs in the same cycle.
REQ-013 m_data SHALL hold the oldest unpopped word whenever m_valid=1, and SHALL stay stable while m_valid=1 and m_ready=0.
REQ-014 Storage SHALL be one 1-cycle-latency BRAM: port A write-only (push), port B read-only (head prefetch).
REQ-015 Read-first collision: a read and write to the same address in the same cycle SHALL never be used as the source of m_data.
REQ-016 Latency from empty: a word accepted at edge N SHALL give m_valid=1 with that word after edge N+2, and not earlier.
REQ-017 Throughput: with level>=2, one push and one pop SHALL be sustained every cycle with no bubble on m_valid.
REQ-018 m_valid SHALL be 0 whenever level==0, and SHALL be 1 no later than 2 cycles after level becomes non-zero.
REQ-019 Simultaneous push and pop (0<level<DEPTH) SHALL leave level unchanged, so level' = level + push - pop.
REQ-020 Both pointers SHALL be ADDR_WIDTH+1 bits wide and wrap modulo 2*DEPTH.
REQ-021 Full/empty SHALL be decoded from the pointer MSB and lower bits; wrap-around SHALL NOT disturb ordering.
REQ-022 flush=1 SHALL take priority over a push and pop in the same cycle.
REQ-023 After the edge where flush=1, the block SHALL have: pointers equal, level=0, m_valid=0, s_ready=1.
REQ-024 Any BRAM read in flight when flush is applied SHALL be discarded.

Reset
REQ-025 While rst_n=0, the block SHALL hold: level=0, empty=1, full=0, s_ready=1, m_valid=0, m_data=0, pointers=0.
REQ-026 Reset asserted mid-transfer SHALL drop all contents immediately, without waiting for a clock.
REQ-027 After rst_n deassertion, the first push SHALL be accepted on the first rising edge.
REQ-028 BRAM contents SHALL NOT be reset.

Configuration
REQ-029 Macro BRAM_FIFO_STATS_EN defined: the block SHALL add output max_level  ADDR_WIDTH+1, a high-water mark of level, cleared by reset and by flush, updated each edge to max(max_level, level').
REQ-030 Macro BRAM_FIFO_STATS_EN undefined: the port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package bram_fifo_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants and the typedef of the pointer type (ADDR_WIDTH+1 bits).
REQ-032 Storage SHALL be a single instance of the existing dual_port_ram sub-module, with both ports clocked by clk and en tied high on the read port.
REQ-033 Pointer, prefetch and valid control SHALL be implemented in bram_fifo itself; no other sub-module is used.

Verification
REQ-034 Reset-then-push: push 0xA5A5A5A5 at edge 1, m_ready=0 -> m_valid=1 after edge 3, m_data=0xA5A5A5A5, level=1, and data held stable while stalled.
REQ-035 Fill: 16 pushes with m_ready=0 -> full=1, s_ready=0, level=16; a 17th push with s_valid=1 is not accepted.
REQ-036 Streaming: 40 consecutive words 0..39 with s_valid=m_ready=1 continuously -> output in order, no gaps after the first valid, pointers wrap twice.
REQ-037 Full plus pop: at level=16, s_valid=1 and m_ready=1 -> pop only; level=15; s_ready=1 on the next cycle.
REQ-038 Flush: at level=5, assert flush with s_valid=1 and m_ready=1 -> level=0, m_valid=0 next cycle; the next pushed word 0x11 is the next word popped.
REQ-039 Async reset: assert rst_n low mid-stream between clock edges -> m_valid=0 and level=0 before the next edge; if BRAM_FIFO_STATS_EN is defined, max_level=0.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo_pkg
// Description : Shared constants and types for the BRAM-backed FIFO.
//               c_DATA_WIDTH_DEF / c_ADDR_WIDTH_DEF are the default word
//               width and log2 depth. ptr_t is the read/write pointer type
//               for the default depth. It carries one extra wrap bit so that
//               full and empty can be told apart.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_fifo_pkg;

    localparam int c_DATA_WIDTH_DEF = 32;
    localparam int c_ADDR_WIDTH_DEF = 4;

    // Pointer with a wrap bit: wraps modulo 2*DEPTH
    typedef logic [c_ADDR_WIDTH_DEF:0] ptr_t;

endpackage : bram_fifo_pkg
`default_nettype wire

// File: rtl/dual_port_ram.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_ram
// Description : Simple dual-port block RAM.
//               Port A is write-only. Port B is a registered read with
//               1-cycle latency. A same-address access on both ports in one
//               cycle returns the old contents on port B (read-first).
//               The contents have no reset.
// Ports       : i_clk_a, i_en_a, i_we_a, i_addr_a, i_din_a  - write port
//               i_clk_b, i_en_b, i_addr_b, o_dout_b         - read port
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk_a,
    input  logic                  i_en_a,
    input  logic                  i_we_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [DATA_WIDTH-1:0] i_din_a,
    input  logic                  i_clk_b,
    input  logic                  i_en_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    output logic [DATA_WIDTH-1:0] o_dout_b
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_dout_b;

    always_ff @(posedge i_clk_a) begin
        if (i_en_a && i_we_a) begin
            r_mem[i_addr_a] <= i_din_a;
        end
    end

    always_ff @(posedge i_clk_b) begin
        if (i_en_b) begin
            r_dout_b <= r_mem[i_addr_b];
        end
    end

    assign o_dout_b = r_dout_b;

endmodule : dual_port_ram
`default_nettype wire

// File: rtl/bram_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_fifo
// Description : First-word-fall-through FIFO built on one dual_port_ram.
//               The head word flows through two stages: the BRAM output
//               register, then the m_data output register. A word pushed
//               into an empty FIFO appears on m_data two edges after it
//               was accepted.
// Ports       : clk, rst_n (async, active-low), flush (sync discard)
//               s_data/s_valid/s_ready  - write handshake
//               m_data/m_valid/m_ready  - read handshake (FWFT)
//               level, full, empty      - occupancy
//               max_level               - high-water mark of level
//                                         (present only with
//                                         BRAM_FIFO_STATS_EN defined)
// Config      : `define BRAM_FIFO_STATS_EN to add the max_level port
// Revision    : 1.0 - initial release
// ============================================================================
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty
`ifdef BRAM_FIFO_STATS_EN
    ,
    output logic [ADDR_WIDTH:0]   max_level
`endif
);

    localparam logic [ADDR_WIDTH:0] c_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // r_wr_ptr    : next write slot
    // r_rd_ptr    : head word (popped words are behind it)
    // r_fetch_ptr : next word still to be read out of the BRAM
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_fetch_ptr;
    logic                  r_dout_vld;   // BRAM output holds an unconsumed word
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_fetch;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_hold_addr;
    logic [DATA_WIDTH-1:0] w_ram_dout;

    assign level   = r_wr_ptr - r_rd_ptr;
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign s_ready = ~full;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    assign w_push  = s_valid & ~full;
    assign w_pop   = r_m_valid & m_ready;
    assign w_wr_en = w_push & ~flush;

    // The output register takes the BRAM word when it is empty or being popped
    assign w_load  = r_dout_vld & (~r_m_valid | w_pop);

    // Start a new read only when the BRAM output stage will be free. The
    // fetch pointer trails the write pointer, so the addressed word was
    // written on an earlier edge and never collides with this cycle's write.
    assign w_fetch = (r_fetch_ptr != r_wr_ptr) & (~r_dout_vld | w_load);

    // While a fetched word waits, keep re-reading its slot so the BRAM output
    // stays stable. That slot is unpopped, so it cannot be overwritten.
    assign w_hold_addr = r_fetch_ptr[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign w_rd_addr   = w_fetch ? r_fetch_ptr[ADDR_WIDTH-1:0] : w_hold_addr;

    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk_a  (clk),
        .i_en_a   (w_wr_en),
        .i_we_a   (w_wr_en),
        .i_addr_a (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_din_a  (s_data),
        .i_clk_b  (clk),
        .i_en_b   (1'b1),
        .i_addr_b (w_rd_addr),
        .o_dout_b (w_ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fetch_ptr <= '0;
            r_dout_vld  <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
        end else if (flush) begin
            // Dropping r_dout_vld also discards any BRAM read in flight
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fetch_ptr <= '0;
            r_dout_vld  <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_fetch) begin
                r_fetch_ptr <= r_fetch_ptr + c_PTR_ONE;
            end
            r_dout_vld <= w_fetch | (r_dout_vld & ~w_load);
            if (w_load) begin
                r_m_data  <= w_ram_dout;
                r_m_valid <= 1'b1;
            end else if (w_pop) begin
                r_m_valid <= 1'b0;
            end
        end
    end

`ifdef BRAM_FIFO_STATS_EN
    logic [ADDR_WIDTH:0] w_level_next;
    logic [ADDR_WIDTH:0] r_max_level;

    assign w_level_next = level + (w_push ? c_PTR_ONE : '0) - (w_pop ? c_PTR_ONE : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_level <= '0;
        end else if (flush) begin
            r_max_level <= '0;
        end else if (w_level_next > r_max_level) begin
            r_max_level <= w_level_next;
        end
    end

    assign max_level = r_max_level;
`endif

endmodule : bram_fifo
`default_nettype wire

// File: tb/tb_bram_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_fifo
// Description : Self-checking bench for bram_fifo (default parameters).
//               Words are queued when accepted and compared when popped.
//               Occupancy is checked against a bench-side count every cycle.
// Config      : honours BRAM_FIFO_STATS_EN (max_level checks)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_fifo;

    localparam int c_DW    = 32;
    localparam int c_AW    = 4;
    localparam int c_DEPTH = 16;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [c_DW-1:0] s_data;
    logic            s_valid;
    logic            s_ready;
    logic [c_DW-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic [c_AW:0]   level;
    logic            full;
    logic            empty;
`ifdef BRAM_FIFO_STATS_EN
    logic [c_AW:0]   max_level;
`endif

    bram_fifo #(
        .DATA_WIDTH (c_DW),
        .ADDR_WIDTH (c_AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .level     (level),
        .full      (full),
        .empty     (empty)
`ifdef BRAM_FIFO_STATS_EN
        ,
        .max_level (max_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_tests = 0;
    int              n_fail  = 0;
    int              n_pops  = 0;
    int              mdl_level = 0;
    logic [c_DW-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: note what the edge will accept, take the edge, then update
    // the scoreboard and occupancy model and check them.
    task automatic step();
        logic            wp;
        logic            rp;
        logic [c_DW-1:0] sd;
        logic [c_DW-1:0] pd;
        logic [c_DW-1:0] ed;
        wp = rst_n && !flush && s_valid && s_ready;
        rp = rst_n && !flush && m_valid && m_ready;
        sd = s_data;
        pd = m_data;
        @(posedge clk);
        #1;
        if (!rst_n || flush) begin
            sb.delete();
            mdl_level = 0;
        end else begin
            if (rp) begin
                n_pops++;
                if (sb.size() == 0) begin
                    chk("pop_from_empty", 64'd1, 64'd0);
                end else begin
                    ed = sb.pop_front();
                    chk("pop_data", pd, ed);
                end
                mdl_level--;
            end
            if (wp) begin
                sb.push_back(sd);
                mdl_level++;
            end
        end
        chk("level", level, mdl_level);
        chk("empty", empty, mdl_level == 0);
        chk("full", full, mdl_level == c_DEPTH);
        chk("s_ready", s_ready, mdl_level != c_DEPTH);
        if (mdl_level == 0) chk("m_valid_when_empty", m_valid, 0);
    endtask

    int pushed;
    int gaps;
    int pops0;
    bit seen;

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
`ifdef BRAM_FIFO_STATS_EN
        chk("rst_max_level", max_level, 0);
`endif

        // Reset then push: first edge accepts, valid after the third edge
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hA5A5_A5A5;
        step();
        s_valid = 1'b0;
        chk("lat_edge1_valid", m_valid, 0);
        step();
        chk("lat_edge2_valid", m_valid, 0);
        step();
        chk("lat_edge3_valid", m_valid, 1);
        chk("lat_edge3_data", m_data, 32'hA5A5_A5A5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, 32'hA5A5_A5A5);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Fill to full, then try a 17th push
        s_valid = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            s_data = 32'h100 + i;
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_s_ready", s_ready, 0);
        chk("fill_level", level, 16);
`ifdef BRAM_FIFO_STATS_EN
        chk("fill_max_level", max_level, 16);
`endif
        s_data = 32'hDEAD;
        step();
        chk("push17_level", level, 16);

        // Full plus pop: only the pop happens
        m_ready = 1'b1;
        step();
        chk("fullpop_level", level, 15);
        chk("fullpop_s_ready", s_ready, 1);
        s_valid = 1'b0;
        for (int k = 0; k < 40 && mdl_level != 0; k++) step();
        chk("drain_level", level, 0);

        // Streaming 40 words with continuous push and pop
        pushed = 0;
        gaps   = 0;
        seen   = 1'b0;
        pops0  = n_pops;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && (n_pops - pops0) < 40; cyc++) begin
            s_valid = (pushed < 40);
            s_data  = pushed;
            if (s_valid && s_ready) pushed++;
            step();
            if (seen && !m_valid && (n_pops - pops0) < 40) gaps++;
            if (m_valid) seen = 1'b1;
        end
        s_valid = 1'b0;
        chk("stream_pops", n_pops - pops0, 40);
        chk("stream_gaps", gaps, 0);

        // Flush at level 5 with push and pop requested
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 32'h200 + i;
            step();
        end
        chk("preflush_level", level, 5);
        flush   = 1'b1;
        s_data  = 32'h77;
        m_ready = 1'b1;
        step();
        flush   = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_m_valid", m_valid, 0);
        chk("flush_s_ready", s_ready, 1);
`ifdef BRAM_FIFO_STATS_EN
        chk("flush_max_level", max_level, 0);
`endif
        m_ready = 1'b0;
        s_data  = 32'h11;
        step();
        s_valid = 1'b0;
        for (int k = 0; k < 5 && !m_valid; k++) step();
        chk("postflush_valid", m_valid, 1);
        chk("postflush_data", m_data, 32'h11);
        m_ready = 1'b1;
        step();

        // Async reset in the middle of a stream, between edges
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 32'h300 + i;
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", m_valid, 0);
        chk("async_level", level, 0);
        chk("async_empty", empty, 1);
`ifdef BRAM_FIFO_STATS_EN
        chk("async_max_level", max_level, 0);
`endif
        sb.delete();
        mdl_level = 0;
        s_valid = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h55;
        step();
        s_valid = 1'b0;
        for (int k = 0; k < 10 && mdl_level != 0; k++) step();
        chk("recover_level", level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_bram_fifo
`default_nettype wire
